pipe_stage: RTL

PIPE_STAGE -- requirements
Module: pipe_stage

---
 rtl/pipe_pkg.sv | 17 +
 rtl/pipe_perf_cnt.sv | 25 ++
 rtl/pipe_stage.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared types and defaults for the pipe_stage skid-buffer slice.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } pipe_state_t;

    localparam int PIPE_DATA_W_DEF = 32;
    localparam int PIPE_CTRL_W_DEF = 4;

    function automatic logic has_room(input pipe_state_t s);
        return s != FULL;
    endfunction

endpackage

// File: rtl/pipe_perf_cnt.sv
// Saturating event counter used for the stage stall/bubble statistics.
module pipe_perf_cnt
    import pipe_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/pipe_stage.sv
// Two-entry skid-buffered pipeline stage with registered in_ready.
// Define PIPE_STAGE_PERF_EN to build the stall/bubble counters.
module pipe_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W = PIPE_DATA_W_DEF,
    parameter int CTRL_W = PIPE_CTRL_W_DEF,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    pipe_state_t       r_state;
    pipe_state_t       w_state_nxt;
    logic              r_in_ready;
    logic [DATA_W-1:0] r_main_data;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic [DATA_W-1:0] r_skid_data;
    logic [CTRL_W-1:0] r_skid_ctrl;
    logic              w_in_xfer;
    logic              w_out_xfer;
    logic              w_out_valid;
    logic              w_load_main;
    logic              w_load_skid;
    logic              w_pop_skid;

    assign w_in_xfer  = in_valid & r_in_ready;
    assign w_out_xfer = w_out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load_main = 1'b0;
        w_load_skid = 1'b0;
        w_pop_skid  = 1'b0;
        if (flush) begin
            w_state_nxt = EMPTY;
        end else begin
            unique case (r_state)
                EMPTY: begin
                    if (w_in_xfer) begin
                        w_state_nxt = BUSY;
                        w_load_main = 1'b1;
                    end
                end
                BUSY: begin
                    if (w_in_xfer && w_out_xfer) begin
                        w_load_main = 1'b1;
                    end else if (w_in_xfer) begin
                        w_state_nxt = FULL;
                        w_load_skid = 1'b1;
                    end else if (w_out_xfer) begin
                        w_state_nxt = EMPTY;
                    end
                end
                FULL: begin
                    if (out_ready) begin
                        w_state_nxt = BUSY;
                        w_pop_skid  = 1'b1;
                    end
                end
                default: w_state_nxt = EMPTY;
            endcase
        end
    end

    always_comb begin
        w_out_valid = (r_state == BUSY) || (r_state == FULL);
    end

    // in_ready is a flop fed from the next state, so out_ready never
    // reaches it combinationally.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_in_ready <= 1'b1;
        end else begin
            r_in_ready <= has_room(w_state_nxt);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_main_data <= '0;
            r_main_ctrl <= '0;
            r_skid_data <= '0;
            r_skid_ctrl <= '0;
        end else begin
            if (w_load_main) begin
                r_main_data <= in_data;
                r_main_ctrl <= in_ctrl;
            end else if (w_pop_skid) begin
                r_main_data <= r_skid_data;
                r_main_ctrl <= r_skid_ctrl;
            end
            if (w_load_skid) begin
                r_skid_data <= in_data;
                r_skid_ctrl <= in_ctrl;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = w_out_valid;
    assign out_data  = r_main_data;
    assign out_ctrl  = w_out_valid ? r_main_ctrl : '0;

`ifdef PIPE_STAGE_PERF_EN
    logic w_stall;
    logic w_bubble;

    assign w_stall  = w_out_valid & ~out_ready;
    assign w_bubble = ~w_out_valid;

    pipe_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_inc   (w_stall),
        .o_count (stall_cnt)
    );

    pipe_perf_cnt #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_inc   (w_bubble),
        .o_count (bubble_cnt)
    );
`else
    assign stall_cnt  = '0;
    assign bubble_cnt = '0;
`endif

endmodule
